// File: rtl/fifo_port_sched.sv
// Single-op-per-cycle scheduler in front of a sync FIFO: NUM_WR round-robin
// write requesters with burst grants, one read requester, and alternation
// between reads and writes when both are pending.
module fifo_port_sched #(
    parameter int NUM_WR    = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WR-1:0]    wr_req,
    input  logic [NUM_WR*DW-1:0] wr_data,
    output logic [NUM_WR-1:0]    wr_ack,
    input  logic                 rd_req,
    output logic                 rd_ack,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_valid,
    output logic                 fifo_wr,
    output logic                 fifo_rd,
    output logic [DW-1:0]        fifo_din,
    input  logic [DW-1:0]        fifo_dout,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    output logic [2:0]           owner,
    output logic                 owner_vld
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_WBURST = 1'b1;

    logic [0:0]    state_reg;
    logic [2:0]    owner_reg;
    logic [2:0]    rr_ptr_reg;
    logic [3:0]    burst_cnt_reg;
    logic          last_op_reg;
    logic          rd_valid_reg;

    logic [7:0]    req_ext;
    logic          owner_live;
    logic [2:0]    search_base;
    logic [2:0]    winner;
    logic [2:0]    wr_idx;
    logic          wr_ok;
    logic          rd_ok;
    logic          issue_wr;
    logic          issue_rd;
    logic [DW-1:0] din_term [NUM_WR];

    function automatic logic [2:0] next_idx(input logic [2:0] x);
        return (x == 3'(NUM_WR - 1)) ? 3'd0 : x + 3'd1;
    endfunction

    // Widen the request vector so 3-bit indices never select past its end
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_WR-1:0]    = wr_req;
    end

    // An owner that dropped its request releases at cycle start; the same
    // cycle is then arbitrated from the slot after it, so no bubble appears
    always_comb begin
        owner_live  = (state_reg == ST_WBURST) && req_ext[owner_reg];
        search_base = ((state_reg == ST_WBURST) && !owner_live) ? next_idx(owner_reg) : rr_ptr_reg;
    end

    // Round-robin search; walking downward lets the nearest requester win
    always_comb begin
        logic [3:0] sum;
        winner = '0;
        sum    = '0;
        for (int k = NUM_WR - 1; k >= 0; k--) begin
            sum = {1'b0, search_base} + 4'(k);
            if (sum >= 4'(NUM_WR)) begin
                sum = sum - 4'(NUM_WR);
            end
            if (req_ext[sum[2:0]]) begin
                winner = sum[2:0];
            end
        end
    end

    // Pick at most one FIFO operation; when both are eligible the op not
    // issued last time goes first. Nothing issues while in reset.
    always_comb begin
        wr_ok    = (|wr_req) && !fifo_full;
        rd_ok    = rd_req && !fifo_empty;
        wr_idx   = owner_live ? owner_reg : winner;
        issue_rd = rst && rd_ok && (!wr_ok || !last_op_reg);
        issue_wr = rst && wr_ok && !issue_rd;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_ack
            assign wr_ack[gi]   = issue_wr && (wr_idx == 3'(gi));
            assign din_term[gi] = wr_data[gi*DW +: DW] & {DW{wr_ack[gi]}};
        end
    endgenerate

    // Write data mux built from the one-hot ack; zero when nothing is written
    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            fifo_din = fifo_din | din_term[i];
        end
    end

    assign fifo_wr   = issue_wr;
    assign fifo_rd   = issue_rd;
    assign rd_ack    = issue_rd;
    assign rd_data   = fifo_dout;
    assign rd_valid  = rd_valid_reg;
    assign owner     = owner_reg;
    assign owner_vld = (state_reg == ST_WBURST);

    // Grant bookkeeping, fairness pointer, last-op memory and read valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
            last_op_reg   <= 1'b1;
            rd_valid_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= issue_rd;
            if (issue_wr || issue_rd) begin
                last_op_reg <= issue_rd;
            end
            if (issue_wr && owner_live) begin
                if (burst_cnt_reg + 4'd1 == 4'(MAX_BURST)) begin
                    state_reg     <= ST_IDLE;
                    rr_ptr_reg    <= next_idx(owner_reg);
                    burst_cnt_reg <= '0;
                end else begin
                    burst_cnt_reg <= burst_cnt_reg + 4'd1;
                end
            end else if (issue_wr) begin
                owner_reg <= wr_idx;
                if (MAX_BURST == 1) begin
                    state_reg     <= ST_IDLE;
                    rr_ptr_reg    <= next_idx(wr_idx);
                    burst_cnt_reg <= '0;
                end else begin
                    state_reg     <= ST_WBURST;
                    burst_cnt_reg <= 4'd1;
                end
            end else if ((state_reg == ST_WBURST) && !owner_live) begin
                state_reg     <= ST_IDLE;
                rr_ptr_reg    <= next_idx(owner_reg);
                burst_cnt_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_port_sched.sv
// Randomized bench for fifo_port_sched: a 16-entry behavioural FIFO sits on
// the FIFO pins, and a rule-level scheduler model predicts every output.
module tb_fifo_port_sched;

    localparam int NUM_WR    = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_WR-1:0]    wr_req;
    logic [NUM_WR*DW-1:0] wr_data;
    logic [NUM_WR-1:0]    wr_ack;
    logic                 rd_req;
    logic                 rd_ack;
    logic [DW-1:0]        rd_data;
    logic                 rd_valid;
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic [DW-1:0]        fifo_din;
    logic [DW-1:0]        fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [2:0]           owner;
    logic                 owner_vld;

    fifo_port_sched #(.NUM_WR(NUM_WR), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din), .fifo_dout(fifo_dout),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .owner(owner), .owner_vld(owner_vld)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment FIFO (driven by the DUT pins) and expected-content queue
    logic [DW-1:0] env_q [$];
    logic [DW-1:0] mdl_q [$];

    // Scheduler model state, stated in terms of grants and beats
    bit            m_grant;
    int            m_owner;
    int            m_beats;
    int            m_rr;
    bit            m_last_rd;
    bit            exp_rdv;
    logic [DW-1:0] exp_rdata;
    logic [NUM_WR-1:0] last_ack;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_grant   = 1'b0;
        m_owner   = 0;
        m_beats   = 0;
        m_rr      = 0;
        m_last_rd = 1'b1;
        exp_rdv   = 1'b0;
    endtask

    task automatic run_cycle(input int mask, input int p_req, input int p_rd, input int p_drop,
                             input bit rst_val);
        bit own_live, wr_ok, rd_ok, do_wr, do_rd;
        int start, winner, widx, idx;
        logic [NUM_WR-1:0] exp_ack;
        logic [DW-1:0] exp_din;
        bit dut_wr, dut_rd;
        logic [DW-1:0] dut_din;

        @(negedge clk);
        rst = rst_val;
        for (int i = 0; i < NUM_WR; i++) begin
            if (!mask[i]) begin
                wr_req[i] = 1'b0;
            end else if (wr_req[i] && last_ack[i]) begin
                wr_req[i] = ($urandom_range(99) < p_req);
                wr_data[i*DW +: DW] = DW'($urandom);
            end else if (wr_req[i]) begin
                if ($urandom_range(99) < p_drop) wr_req[i] = 1'b0;
            end else begin
                wr_req[i] = ($urandom_range(99) < p_req);
                wr_data[i*DW +: DW] = DW'($urandom);
            end
        end
        rd_req = ($urandom_range(99) < p_rd);
        #1;

        // Expected decision for this cycle
        own_live = m_grant && wr_req[m_owner];
        start    = (m_grant && !own_live) ? (m_owner + 1) % NUM_WR : m_rr;
        winner   = -1;
        for (int k = 0; k < NUM_WR; k++) begin
            idx = (start + k) % NUM_WR;
            if (winner < 0 && wr_req[idx]) winner = idx;
        end
        widx  = own_live ? m_owner : winner;
        wr_ok = !fifo_full && (own_live || winner >= 0);
        rd_ok = rd_req && !fifo_empty;
        if (!rst) begin
            do_wr = 1'b0; do_rd = 1'b0;
        end else if (wr_ok && rd_ok) begin
            do_rd = !m_last_rd; do_wr = m_last_rd;
        end else begin
            do_wr = wr_ok; do_rd = rd_ok;
        end
        exp_ack = do_wr ? NUM_WR'(1 << widx) : '0;
        exp_din = do_wr ? wr_data[widx*DW +: DW] : '0;

        check_val("wr_ack", wr_ack, exp_ack);
        check_val("fifo_wr", fifo_wr, do_wr);
        check_val("fifo_rd", fifo_rd, do_rd);
        check_val("rd_ack", rd_ack, do_rd);
        check_val("fifo_din", fifo_din, exp_din);
        check_val("one_op", fifo_wr & fifo_rd, 0);
        check_val("owner_vld", owner_vld, m_grant);
        if (m_grant) check_val("owner", owner, m_owner);
        check_val("rd_valid", rd_valid, exp_rdv);
        if (exp_rdv) check_val("rd_data", rd_data, exp_rdata);

        if (do_wr) $display("txn t=%0t WR req=%0d data=%02h", $time, widx, exp_din);
        if (do_rd) $display("txn t=%0t RD level=%0d", $time, mdl_q.size());

        dut_wr  = fifo_wr;
        dut_rd  = fifo_rd;
        dut_din = fifo_din;

        @(posedge clk);
        #1;
        // Environment FIFO: writes win, reads on empty/writes on full ignored
        if (dut_wr) begin
            if (env_q.size() < DEPTH) env_q.push_back(dut_din);
        end else if (dut_rd && env_q.size() > 0) begin
            fifo_dout = env_q.pop_front();
        end
        fifo_full  = (env_q.size() >= DEPTH);
        fifo_empty = (env_q.size() == 0);

        // Model update
        if (!rst) begin
            model_reset();
        end else begin
            if (m_grant && !own_live) begin
                m_grant = 1'b0;
                m_rr    = (m_owner + 1) % NUM_WR;
            end
            if (do_wr) begin
                if (own_live) begin
                    m_beats++;
                end else begin
                    m_owner = widx; m_beats = 1; m_grant = 1'b1;
                end
                if (m_beats == MAX_BURST) begin
                    m_grant = 1'b0; m_beats = 0;
                    m_rr = (m_owner + 1) % NUM_WR;
                end
                mdl_q.push_back(exp_din);
            end
            if (do_rd) begin
                if (mdl_q.size() > 0) exp_rdata = mdl_q.pop_front();
            end
            if (do_wr || do_rd) m_last_rd = do_rd;
            exp_rdv = do_rd;
        end
        last_ack = exp_ack;
    endtask

    initial begin
        rst        = 1'b0;
        wr_req     = '0;
        wr_data    = '0;
        rd_req     = 1'b0;
        fifo_dout  = '0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b1;
        last_ack   = '0;
        exp_rdata  = '0;
        model_reset();

        repeat (3) run_cycle(0, 0, 0, 0, 1'b0);
        check_val("rst_owner", owner, 0);
        check_val("rst_owner_vld", owner_vld, 0);
        check_val("rst_rd_valid", rd_valid, 0);

        // Single requester bursts, then all requesters with light reads
        repeat (12)  run_cycle(4'b0001, 100, 0, 0, 1'b1);
        repeat (60)  run_cycle(4'b1111, 100, 30, 0, 1'b1);
        // Fill to full, then requester 2 vs reads at full
        repeat (30)  run_cycle(4'b1111, 100, 0, 0, 1'b1);
        repeat (20)  run_cycle(4'b0100, 100, 100, 0, 1'b1);
        // Mixed traffic with abandoned requests
        repeat (400) run_cycle(4'b1111, 50, 50, 10, 1'b1);
        // Drain until empty; reads on empty must be ignored
        repeat (30)  run_cycle(4'b0000, 0, 100, 0, 1'b1);
        // Reset in the middle of a burst
        repeat (2)   run_cycle(4'b1111, 100, 0, 0, 1'b1);
        run_cycle(4'b1111, 100, 0, 0, 1'b0);
        check_val("midrst_owner_vld", owner_vld, 0);
        check_val("midrst_owner", owner, 0);
        repeat (10)  run_cycle(4'b1111, 100, 0, 0, 1'b1);
        // Randomized mixes with occasional resets
        for (int p = 0; p < 20; p++) begin
            int mask, preq, prd, pdrop;
            mask  = $urandom_range(15);
            preq  = $urandom_range(100);
            prd   = $urandom_range(100);
            pdrop = $urandom_range(20);
            repeat (100) run_cycle(mask, preq, prd, pdrop, ($urandom_range(199) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
